// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between the instruction-cache
// and data-cache controllers. It issues 8-word block fills for read misses and
// single-word write-through stores, routes returned words back with their index,
// and produces the stalls that hold each requester until its work is finished.
//
// Handshake: a requester holds *_req (with its address/data stable) for as long
// as its *_stall output reads 1. A store is accepted in the cycle where d_stall
// reads 0. A fill is complete in the cycle where the stall drops (the DONE
// state). The memory port has no back-pressure. Each cycle with mem_en=1 is one
// accepted command, and every read gets exactly one mem_rvalid pulse, returned
// in issue order.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_word,
  output logic             i_fill_valid,
  output logic             d_fill_valid,
  output logic             i_stall,
  output logic             d_stall,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_FILL = 3'd1,
    S_D_FILL = 3'd2,
    S_I_DONE = 3'd3,
    S_D_DONE = 3'd4
  } state_t;

  localparam logic [IDX_W:0]   ISS_MAX  = (IDX_W+1)'(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_RCV = IDX_W'(BLOCK_WORDS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W:0]   r_iss;
  logic [IDX_W-1:0] r_rcv;
  logic [15:0]      r_base;

  logic             w_fill;
  logic             w_issue;
  logic             w_start;
  logic [15:0]      w_start_addr;

  // Fill bookkeeping: an issue slot remains while fewer than BLOCK_WORDS reads have gone out.
  always_comb begin
    w_fill  = (r_state == S_I_FILL) || (r_state == S_D_FILL);
    w_issue = w_fill && (r_iss < ISS_MAX);
  end

  // Next-state selection and memory-port / fill-return drive.
  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_start_addr = 16'h0000;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req && d_wr) begin
          // Write-through store goes straight out. The FSM stays in IDLE.
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end else if (d_req) begin
          w_next       = S_D_FILL;
          w_start      = 1'b1;
          w_start_addr = d_addr;
        end else if (i_req) begin
          w_next       = S_I_FILL;
          w_start      = 1'b1;
          w_start_addr = i_addr;
        end
      end
      S_I_FILL, S_D_FILL: begin
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = r_base + 16'({r_iss, 1'b0});
        end
        if (mem_rvalid) begin
          i_fill_valid = (r_state == S_I_FILL);
          d_fill_valid = (r_state == S_D_FILL);
          if (r_rcv == LAST_RCV)
            w_next = (r_state == S_I_FILL) ? S_I_DONE : S_D_DONE;
        end
      end
      S_I_DONE, S_D_DONE: w_next = S_IDLE;
      default:            w_next = S_IDLE;
    endcase
  end

  // State, counters and block base. The counters are cleared whenever a fill starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iss   <= '0;
      r_rcv   <= '0;
      r_base  <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_iss  <= '0;
        r_rcv  <= '0;
        r_base <= w_start_addr & 16'hFFF0;
      end else if (w_fill) begin
        if (w_issue)    r_iss <= r_iss + 1'b1;
        if (mem_rvalid) r_rcv <= r_rcv + 1'b1;
      end
    end
  end

  // Returned word, its index, the stalls and the debug view of the state.
  always_comb begin
    fill_data = mem_rdata;
    fill_word = r_rcv;
    d_stall   = d_req & (d_wr ? (r_state != S_IDLE) : (r_state != S_D_DONE));
    i_stall   = i_req & (r_state != S_I_DONE);
    dbg_state = r_state;
  end

endmodule
